// File: rtl/button_debouncer_fsm.sv
// Push-button debouncer: 2-FF synchronizer plus a tick-sampled 4-state FSM.
// Emits a registered debounced level and one-clock rise/fall pulses.
module button_debouncer_fsm #(
    parameter int N_STABLE = 4,
    parameter bit INVERT   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic       tick,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [1:0] state_out
);
    localparam int CW = $clog2(N_STABLE + 1);
    localparam logic [CW-1:0] LAST = CW'(N_STABLE - 1);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        RISING  = 2'd1,
        HIGH    = 2'd2,
        FALLING = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sync1, sync2, btn_s;
    logic          level_nxt, rise_nxt, fall_nxt, bad_state;

    // Flops reset to INVERT so the synchronized button reads released.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            sync1 <= INVERT;
            sync2 <= INVERT;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign btn_s = sync2 ^ INVERT;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bad_state = 1'b0;
        unique case (state)
            LOW: begin
                if (tick && btn_s) begin
                    if (N_STABLE == 1) begin
                        state_nxt = HIGH;
                    end else begin
                        state_nxt = RISING;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            RISING: begin
                if (tick) begin
                    if (!btn_s) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == LAST) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            HIGH: begin
                if (tick && !btn_s) begin
                    if (N_STABLE == 1) begin
                        state_nxt = LOW;
                    end else begin
                        state_nxt = FALLING;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            FALLING: begin
                if (tick) begin
                    if (btn_s) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == LAST) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
                bad_state = 1'b1;
            end
        endcase
        level_nxt = (state_nxt == HIGH) || (state_nxt == FALLING);
        rise_nxt  = level_nxt && !btn_level && !bad_state;
        fall_nxt  = !level_nxt && btn_level && !bad_state;
    end

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state      <= LOW;
            cnt        <= '0;
            btn_level  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            btn_level  <= level_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_button_debouncer_fsm.sv
// Directed bench for button_debouncer_fsm: default instance with a
// 1-in-4 tick, plus an INVERT=1 N_STABLE=1 instance with tick held high.
module tb_button_debouncer_fsm;
    logic       clk = 1'b0;
    logic       rst_a_p = 1'b1;
    logic       tick = 1'b0;
    logic       btn_in = 1'b0;
    logic       btn_level, rise_pulse, fall_pulse;
    logic [1:0] state_out;

    logic       btn2 = 1'b1;
    logic       level2, rise2, fall2;
    logic [1:0] state2;

    int total = 0;
    int bad = 0;
    int tcnt = 0;
    bit tick_on = 1'b1;
    int rise_n = 0;
    int fall_n = 0;
    int rise2_n = 0;
    int fall2_n = 0;

    always #5 clk = ~clk;

    button_debouncer_fsm #(.N_STABLE(4), .INVERT(1'b0)) u_dut (
        .clk       (clk),
        .rst_a_p   (rst_a_p),
        .tick      (tick),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .state_out (state_out)
    );

    button_debouncer_fsm #(.N_STABLE(1), .INVERT(1'b1)) u_inv (
        .clk       (clk),
        .rst_a_p   (rst_a_p),
        .tick      (1'b1),
        .btn_in    (btn2),
        .btn_level (level2),
        .rise_pulse(rise2),
        .fall_pulse(fall2),
        .state_out (state2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, then set up tick for the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        rise_n  += int'(rise_pulse);
        fall_n  += int'(fall_pulse);
        rise2_n += int'(rise2);
        fall2_n += int'(fall2);
        if (rise_pulse && fall_pulse) chk("both_pulses", 1, 0);
        tick = tick_on && (tcnt % 4 == 3);
        tcnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic start_phase();
        tcnt = 0;
        tick = 1'b0;
        rise_n = 0;
        fall_n = 0;
        rise2_n = 0;
        fall2_n = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_a_p = 1'b1;
        run(2);
        rst_a_p = 1'b0;
        start_phase();
    endtask

    initial begin
        do_reset();
        chk("rst_state", state_out, 0);
        chk("rst_level", btn_level, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_level2", level2, 0);

        // clean press
        btn_in = 1'b1;
        run(16);
        chk("press_c16_level", btn_level, 0);
        chk("press_c16_state", state_out, 1);
        run(1);
        chk("press_c17_level", btn_level, 1);
        chk("press_c17_rise", rise_pulse, 1);
        chk("press_c17_state", state_out, 2);
        run(1);
        chk("press_c18_rise", rise_pulse, 0);
        run(22);
        chk("press_rise_count", rise_n, 1);
        chk("press_fall_count", fall_n, 0);

        // short low during FALLING returns to HIGH
        start_phase();
        btn_in = 1'b0;
        run(5);
        chk("blip_falling", state_out, 3);
        chk("blip_level_held", btn_level, 1);
        run(1);
        btn_in = 1'b1;
        run(3);
        chk("blip_back_high", state_out, 2);
        run(12);
        chk("blip_level", btn_level, 1);
        chk("blip_fall_count", fall_n, 0);

        // full release
        start_phase();
        btn_in = 1'b0;
        run(16);
        chk("rel_c16_state", state_out, 3);
        chk("rel_c16_level", btn_level, 1);
        run(1);
        chk("rel_c17_level", btn_level, 0);
        chk("rel_c17_fall", fall_pulse, 1);
        chk("rel_c17_state", state_out, 0);
        run(1);
        chk("rel_c18_fall", fall_pulse, 0);
        chk("rel_rise_count", rise_n, 0);

        // bounce: toggle every 3 clk for 30 clk, then settle high
        do_reset();
        for (int s = 0; s < 10; s++) begin
            btn_in = (s % 2 == 0);
            run(3);
        end
        chk("bounce_rise_count", rise_n, 0);
        chk("bounce_level", btn_level, 0);
        btn_in = 1'b1;
        run(10);
        chk("settle_c40_level", btn_level, 0);
        run(1);
        chk("settle_c41_level", btn_level, 1);
        chk("settle_c41_rise", rise_pulse, 1);
        run(10);
        chk("settle_rise_count", rise_n, 1);

        // async reset while RISING with cnt=2
        do_reset();
        btn_in = 1'b1;
        run(10);
        chk("midrst_pre_state", state_out, 1);
        rst_a_p = 1'b1;
        #1;
        chk("midrst_state", state_out, 0);
        chk("midrst_level", btn_level, 0);
        @(posedge clk);
        #1;
        rst_a_p = 1'b0;
        start_phase();
        run(16);
        chk("midrst_c16_level", btn_level, 0);
        run(1);
        chk("midrst_c17_level", btn_level, 1);
        chk("midrst_c17_rise", rise_pulse, 1);

        // no tick: nothing moves
        do_reset();
        tick_on = 1'b0;
        btn_in = 1'b1;
        run(100);
        chk("notick_state", state_out, 0);
        chk("notick_level", btn_level, 0);
        chk("notick_rise_count", rise_n, 0);
        tick_on = 1'b1;

        // INVERT=1, N_STABLE=1, tick always high
        btn_in = 1'b0;
        do_reset();
        btn2 = 1'b0;
        run(2);
        chk("inv_c2_level", level2, 0);
        run(1);
        chk("inv_c3_level", level2, 1);
        chk("inv_c3_rise", rise2, 1);
        chk("inv_c3_state", state2, 2);
        run(1);
        chk("inv_c4_rise", rise2, 0);
        start_phase();
        btn2 = 1'b1;
        run(2);
        chk("inv_rel_c2_level", level2, 1);
        run(1);
        chk("inv_rel_c3_level", level2, 0);
        chk("inv_rel_c3_fall", fall2, 1);
        run(2);
        chk("inv_rel_fall_count", fall2_n, 1);
        chk("inv_rel_rise_count", rise2_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
